// File: rtl/result_checker.sv
// result_checker -- multi-channel compare scoreboard with a session verdict.
//
// A session is opened by start, runs while busy (RUN) and is closed by finish,
// after which done is high (REPORT) and result_ok carries the verdict.
// Every RUN cycle (except a start cycle) each channel with ch_valid set is
// checked: it passes when (expected == actual) XOR ch_mode. Passing and
// failing channels are popcounted into saturating pass_cnt / fail_cnt, and the
// lowest-index failing channel of the first failing cycle is captured.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, finish     session control (start has priority over finish)
//   ch_valid, ch_mode per-channel compare strobe and mode (1 = expect unequal)
//   expected, actual  packed values, channel i at [i*WIDTH +: WIDTH]
//   pass_cnt, fail_cnt saturating per-session counters
//   busy, done        state RUN / state REPORT
//   result_ok         verdict, valid while done
//   first_fail_valid, first_fail_ch  sticky first-failure capture
//
// Optional feature macro RESULT_CHECKER_FAIL_DATA_EN adds first_fail_expected
// and first_fail_actual, the data of the captured failing channel.

// One compare channel: qualified pass/fail strobes.
module result_checker_lane #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic             valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] exp_val,
    input  logic [WIDTH-1:0] act_val,
    output logic             pass,
    output logic             fail
);
    logic match_ok;

    assign match_ok = (exp_val == act_val) ^ mode;
    assign pass     = en & valid & match_ok;
    assign fail     = en & valid & ~match_ok;
endmodule

module result_checker #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      finish,
    input  logic [CHANNELS-1:0]       ch_valid,
    input  logic [CHANNELS-1:0]       ch_mode,
    input  logic [CHANNELS*WIDTH-1:0] expected,
    input  logic [CHANNELS*WIDTH-1:0] actual,
    output logic [CNT_W-1:0]          pass_cnt,
    output logic [CNT_W-1:0]          fail_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      result_ok,
    output logic                      first_fail_valid,
`ifdef RESULT_CHECKER_FAIL_DATA_EN
    output logic [WIDTH-1:0]          first_fail_expected,
    output logic [WIDTH-1:0]          first_fail_actual,
`endif
    output logic [CH_W-1:0]           first_fail_ch
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam int PC_W  = $clog2(CHANNELS + 1);
    // Headroom so a saturated counter plus a full popcount cannot overflow.
    localparam int SUM_W = CNT_W + 5;

    logic [1:0]                     state, state_nxt;
    logic [CHANNELS-1:0][WIDTH-1:0] exp_v, act_v;
    logic                           cmp_en;
    logic [CHANNELS-1:0]            ch_pass, ch_fail;
    logic [PC_W-1:0]                pass_pop, fail_pop;
    logic [CNT_W-1:0]               pass_nxt, fail_nxt;
    logic [CH_W-1:0]                ff_idx;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
    logic [WIDTH-1:0]               ff_exp, ff_act;
`endif

    assign exp_v  = expected;
    assign act_v  = actual;
    // A start cycle restarts the session, so its inputs are not scored.
    assign cmp_en = (state == RUN) && !start;
    assign busy   = (state == RUN);
    assign done   = (state == REPORT);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        result_checker_lane #(.WIDTH(WIDTH)) u_lane (
            .en      (cmp_en),
            .valid   (ch_valid[i]),
            .mode    (ch_mode[i]),
            .exp_val (exp_v[i]),
            .act_val (act_v[i]),
            .pass    (ch_pass[i]),
            .fail    (ch_fail[i])
        );
    end

    always_comb begin
        pass_pop = '0;
        fail_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pass_pop = pass_pop + PC_W'(ch_pass[i]);
            fail_pop = fail_pop + PC_W'(ch_fail[i]);
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}}))
            return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    assign pass_nxt = sat_add(pass_cnt, pass_pop);
    assign fail_nxt = sat_add(fail_cnt, fail_pop);

    // Lowest-index failing channel: scan high to low so the lowest wins.
    always_comb begin
        ff_idx = '0;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
        ff_exp = '0;
        ff_act = '0;
`endif
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_fail[i]) begin
                ff_idx = CH_W'(i);
`ifdef RESULT_CHECKER_FAIL_DATA_EN
                ff_exp = exp_v[i];
                ff_act = act_v[i];
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN;
                     else if (finish) state_nxt = REPORT;
            REPORT:  if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            result_ok        <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_ch    <= '0;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
            first_fail_expected <= '0;
            first_fail_actual   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (start) begin
                pass_cnt         <= '0;
                fail_cnt         <= '0;
                result_ok        <= 1'b0;
                first_fail_valid <= 1'b0;
                first_fail_ch    <= '0;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
                first_fail_expected <= '0;
                first_fail_actual   <= '0;
`endif
            end else if (cmp_en) begin
                pass_cnt <= pass_nxt;
                fail_cnt <= fail_nxt;
                if (!first_fail_valid && |ch_fail) begin
                    first_fail_valid <= 1'b1;
                    first_fail_ch    <= ff_idx;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
                    first_fail_expected <= ff_exp;
                    first_fail_actual   <= ff_act;
`endif
                end
                // Verdict uses the counts including the finish cycle itself.
                if (finish)
                    result_ok <= (fail_nxt == '0) && (pass_nxt != '0);
            end
        end
    end
endmodule

// File: tb/tb_result_checker.sv
module tb_result_checker;
    logic clk, rst_n, start, finish;
    logic [3:0] valid, mode;
    logic [3:0][7:0] exp_v, act_v;

    logic [15:0] p16, f16;
    logic [3:0]  p4, f4;
    logic busy_a, done_a, ok_a, ffv_a, busy_b, done_b, ok_b, ffv_b;
    logic [1:0] ffch_a, ffch_b;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
    logic [7:0] fexp_a, fact_a, fexp_b, fact_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: session state and results as plain variables.
    bit [1:0]  m_state;   // 0 idle, 1 run, 2 report
    bit [15:0] m_p16, m_f16;
    bit [3:0]  m_p4, m_f4;
    bit        m_ok, m_ok4, m_ffv;
    bit [1:0]  m_ffch;
    bit [7:0]  m_fexp, m_fact;

    result_checker #(.WIDTH(8), .CHANNELS(4), .CNT_W(16)) dut_a (
`ifdef RESULT_CHECKER_FAIL_DATA_EN
        .first_fail_expected(fexp_a), .first_fail_actual(fact_a),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .ch_valid(valid), .ch_mode(mode), .expected(exp_v), .actual(act_v),
        .pass_cnt(p16), .fail_cnt(f16), .busy(busy_a), .done(done_a),
        .result_ok(ok_a), .first_fail_valid(ffv_a), .first_fail_ch(ffch_a));

    result_checker #(.WIDTH(8), .CHANNELS(4), .CNT_W(4)) dut_b (
`ifdef RESULT_CHECKER_FAIL_DATA_EN
        .first_fail_expected(fexp_b), .first_fail_actual(fact_b),
`endif
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .ch_valid(valid), .ch_mode(mode), .expected(exp_v), .actual(act_v),
        .pass_cnt(p4), .fail_cnt(f4), .busy(busy_b), .done(done_b),
        .result_ok(ok_b), .first_fail_valid(ffv_b), .first_fail_ch(ffch_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] got_a();
        return {busy_a, done_a, ok_a, ffv_a, ffch_a, p16, f16};
    endfunction
    function automatic logic [37:0] want_a();
        return {m_state == 2'd1, m_state == 2'd2, m_ok, m_ffv, m_ffch, m_p16, m_f16};
    endfunction
    function automatic logic [13:0] got_b();
        return {busy_b, done_b, ok_b, ffv_b, ffch_b, p4, f4};
    endfunction
    function automatic logic [13:0] want_b();
        return {m_state == 2'd1, m_state == 2'd2, m_ok4, m_ffv, m_ffch, m_p4, m_f4};
    endfunction

    task automatic model_reset();
        m_state = 0; m_p16 = 0; m_f16 = 0; m_p4 = 0; m_f4 = 0;
        m_ok = 0; m_ok4 = 0; m_ffv = 0; m_ffch = 0; m_fexp = 0; m_fact = 0;
    endtask

    task automatic set_in(input bit st, input bit fin, input bit [3:0] v, input bit [3:0] m);
        start = st; finish = fin; valid = v; mode = m;
        for (int c = 0; c < 4; c++) begin
            exp_v[c] = 8'($urandom);
            act_v[c] = exp_v[c];
        end
    endtask

    // Advance one clock and apply the session rules to the model.
    task automatic cycle();
        int np, nf, ff, t;
        bit [7:0] fe, fa;
        np = 0; nf = 0; ff = -1; fe = 0; fa = 0;
        if (m_state == 1 && !start) begin
            for (int c = 0; c < 4; c++) begin
                if (valid[c]) begin
                    if ((exp_v[c] == act_v[c]) != mode[c]) np++;
                    else begin
                        nf++;
                        if (ff < 0) begin ff = c; fe = exp_v[c]; fa = act_v[c]; end
                    end
                end
            end
        end
        @(posedge clk); #1;
        if (start) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1) begin
            t = int'(m_p16) + np; m_p16 = (t > 65535) ? 16'hFFFF : 16'(t);
            t = int'(m_f16) + nf; m_f16 = (t > 65535) ? 16'hFFFF : 16'(t);
            t = int'(m_p4) + np;  m_p4  = (t > 15) ? 4'hF : 4'(t);
            t = int'(m_f4) + nf;  m_f4  = (t > 15) ? 4'hF : 4'(t);
            if (ff >= 0 && !m_ffv) begin
                m_ffv = 1; m_ffch = 2'(ff); m_fexp = fe; m_fact = fa;
            end
            if (finish) begin
                m_state = 2;
                m_ok  = (m_f16 == 0) && (m_p16 != 0);
                m_ok4 = (m_f4 == 0) && (m_p4 != 0);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(0, 0, 4'h0, 4'h0);
        model_reset();
        #3;
        n_checks++;
        if (got_a() !== 38'd0) $display("FAIL reset_a: got %h want 0", got_a());
        else n_pass++;
        n_checks++;
        if (got_b() !== 14'd0) $display("FAIL reset_b: got %h want 0", got_b());
        else n_pass++;
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_pass();
        set_in(1, 0, 4'h0, 4'h0); cycle();
        for (int k = 0; k < 3; k++) begin set_in(0, 0, 4'hF, 4'h0); cycle(); end
        set_in(0, 1, 4'h0, 4'h0); cycle();
        n_checks++;
        if ({p16, f16, done_a, ok_a} !== {16'd12, 16'd0, 1'b1, 1'b1})
            $display("FAIL all_pass: got p=%0d f=%0d done=%b ok=%b want 12 0 1 1", p16, f16, done_a, ok_a);
        else n_pass++;
        n_checks++;
        if (got_b() !== want_b()) $display("FAIL all_pass_b: got %h want %h", got_b(), want_b());
        else n_pass++;
        // REPORT holds and ignores finish.
        set_in(0, 1, 4'hF, 4'h0); cycle();
        n_checks++;
        if (got_a() !== want_a()) $display("FAIL report_hold: got %h want %h", got_a(), want_a());
        else n_pass++;
    endtask

    task automatic test_mode();
        set_in(1, 0, 4'h0, 4'h0); cycle();
        set_in(0, 0, 4'b0110, 4'b0100);
        exp_v[1] = 8'h33; act_v[1] = 8'h33;
        exp_v[2] = 8'h5A; act_v[2] = 8'h5A;
        exp_v[0] = 8'h00; act_v[0] = 8'hFF;   // not valid, must be ignored
        cycle();
        set_in(0, 1, 4'h0, 4'h0); cycle();
        n_checks++;
        if ({p16, f16, ffv_a, ffch_a, ok_a, done_a} !== {16'd1, 16'd1, 1'b1, 2'd2, 1'b0, 1'b1})
            $display("FAIL mode: got p=%0d f=%0d ffv=%b ch=%0d ok=%b want 1 1 1 2 0", p16, f16, ffv_a, ffch_a, ok_a);
        else n_pass++;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
        n_checks++;
        if ({fexp_a, fact_a} !== 16'h5A5A) $display("FAIL fail_data: got %h want 5a5a", {fexp_a, fact_a});
        else n_pass++;
`endif
    endtask

    task automatic test_sticky();
        set_in(1, 0, 4'h0, 4'h0); cycle();
        set_in(0, 0, 4'hF, 4'h0); cycle();
        set_in(0, 0, 4'hF, 4'h0); act_v[3] = ~exp_v[3]; cycle();
        set_in(0, 0, 4'hF, 4'h0); cycle();
        set_in(0, 0, 4'hF, 4'h0); act_v[0] = ~exp_v[0]; cycle();
        n_checks++;
        if ({ffv_a, ffch_a, p16, f16} !== {1'b1, 2'd3, 16'd14, 16'd2})
            $display("FAIL sticky: got ffv=%b ch=%0d p=%0d f=%0d want 1 3 14 2", ffv_a, ffch_a, p16, f16);
        else n_pass++;
        set_in(1, 0, 4'hF, 4'h0); act_v[1] = ~exp_v[1]; cycle();
        n_checks++;
        if ({ffv_a, p16, f16, busy_a} !== {1'b0, 16'd0, 16'd0, 1'b1})
            $display("FAIL restart_clear: got ffv=%b p=%0d f=%0d busy=%b want 0 0 0 1", ffv_a, p16, f16, busy_a);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 5; k++) begin set_in(0, 0, 4'hF, 4'h0); cycle(); end
        n_checks++;
        if ({p4, f4, p16} !== {4'd15, 4'd0, 16'd20})
            $display("FAIL saturate: got p4=%0d f4=%0d p16=%0d want 15 0 20", p4, f4, p16);
        else n_pass++;
        set_in(1, 1, 4'hF, 4'h0); cycle();
        n_checks++;
        if ({busy_b, done_b, p4, f4, busy_a, p16} !== {1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 16'd0})
            $display("FAIL start_finish: got busy=%b done=%b p4=%0d p16=%0d want 1 0 0 0", busy_b, done_b, p4, p16);
        else n_pass++;
    endtask

    task automatic test_empty_and_reset();
        set_in(1, 0, 4'h0, 4'h0); cycle();
        set_in(0, 1, 4'h0, 4'h0); cycle();
        n_checks++;
        if ({done_a, ok_a, done_b, ok_b} !== 4'b1010)
            $display("FAIL empty_session: got done=%b ok=%b want 1 0", done_a, ok_a);
        else n_pass++;
        set_in(1, 0, 4'h0, 4'h0); cycle();
        set_in(0, 0, 4'hF, 4'h0); act_v[2] = ~exp_v[2]; cycle();
        set_in(0, 0, 4'hF, 4'h0);
        rst_n = 1'b0;
        #2;
        model_reset();
        n_checks++;
        if (got_a() !== 38'd0) $display("FAIL mid_run_reset: got %h want 0", got_a());
        else n_pass++;
        n_checks++;
        if (got_b() !== 14'd0) $display("FAIL mid_run_reset_b: got %h want 0", got_b());
        else n_pass++;
        #2 rst_n = 1'b1;
        set_in(0, 1, 4'h0, 4'h0);
        cycle();
        n_checks++;
        if (got_a() !== want_a()) $display("FAIL idle_after_reset: got %h want %h", got_a(), want_a());
        else n_pass++;
    endtask

    task automatic test_random();
        int bad_a, bad_b;
        bad_a = 0; bad_b = 0;
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom % 10) == 0, ($urandom % 8) == 0, 4'($urandom), 4'($urandom));
            for (int c = 0; c < 4; c++)
                if ($urandom % 2) act_v[c] = 8'($urandom);
            cycle();
            n_checks++;
            if (got_a() !== want_a()) begin
                if (bad_a < 5) $display("FAIL random_a @%0d: got %h want %h", k, got_a(), want_a());
                bad_a++;
            end else n_pass++;
            n_checks++;
            if (got_b() !== want_b()) begin
                if (bad_b < 5) $display("FAIL random_b @%0d: got %h want %h", k, got_b(), want_b());
                bad_b++;
            end else n_pass++;
`ifdef RESULT_CHECKER_FAIL_DATA_EN
            n_checks++;
            if ({fexp_a, fact_a, fexp_b, fact_b} !== {m_fexp, m_fact, m_fexp, m_fact})
                $display("FAIL random_data @%0d: got %h want %h", k, {fexp_a, fact_a}, {m_fexp, m_fact});
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_mode();
        test_sticky();
        test_saturate();
        test_empty_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter WIDTH, default 8, bit width of one compared value per channel.
REQ-002 Parameter CHANNELS, default 4, number of independent compare channels, range 1..16.
REQ-003 Parameter CNT_W, default 16, width of the pass and fail counters.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  clears all results and begins a check session.
REQ-007 Port finish  input  1  ends the session and publishes the verdict.
REQ-008 Port ch_valid  input  CHANNELS  per-channel "compare this cycle" strobe.
REQ-009 Port ch_mode  input  CHANNELS  per-channel mode: 0 = expect equal, 1 = expect unequal.
REQ-010 Port expected  input  CHANNELS*WIDTH  packed expected values, channel i at bits [i*WIDTH +: WIDTH].
REQ-011 Port actual  input  CHANNELS*WIDTH  packed observed values, same packing as expected.
REQ-012 Port pass_cnt  output  CNT_W  number of passing checks this session.
REQ-013 Port fail_cnt  output  CNT_W  number of failing checks this session.
REQ-014 Port busy  output  1  high while in RUN.
REQ-015 Port done  output  1  high while in REPORT.
REQ-016 Port result_ok  output  1  session verdict, valid while done is high.
REQ-017 Port first_fail_valid  output  1  a failure has been captured this session.
REQ-018 Port first_fail_ch  output  max(1,$clog2(CHANNELS))  index of the first failing channel.

Function
REQ-019 FSM states are IDLE, RUN and REPORT; reset enters IDLE.
REQ-020 IDLE: start -> RUN; finish is ignored.
REQ-021 RUN: start restarts the session (counters and capture cleared, stays RUN) with priority over finish; finish alone -> REPORT.
REQ-022 REPORT: holds all outputs until start -> RUN; finish is ignored.
REQ-023 In RUN, channel i passes when ch_valid[i]=1 and (expected_i==actual_i) XOR ch_mode[i]; otherwise, with ch_valid[i]=1, it fails.
REQ-024 Inputs are compared on every RUN cycle, including the cycle finish is asserted; they are ignored in IDLE, in REPORT and on the start cycle.
REQ-025 pass_cnt and fail_cnt each add the popcount of passing or failing channels for that cycle, visible one cycle after sampling.
REQ-026 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-027 On the first cycle of a session with any failure, the capture latches the lowest-index failing channel and sets first_fail_valid; it is sticky until start or reset.
REQ-028 result_ok = (fail_cnt==0) AND (pass_cnt!=0), registered on entry to REPORT; a session with zero checks is a failure.
REQ-029 start clears pass_cnt, fail_cnt, first_fail_valid, first_fail_ch and result_ok on the following edge.

Reset
REQ-030 While rst_n=0: state IDLE, pass_cnt=0, fail_cnt=0, busy=0, done=0, result_ok=0, first_fail_valid=0, first_fail_ch=0.
REQ-031 Reset asserted mid-RUN discards the session immediately and asynchronously; no verdict is produced.

Configuration
REQ-032 Macro RESULT_CHECKER_FAIL_DATA_EN defined: adds outputs first_fail_expected and first_fail_actual (WIDTH each), latched with first_fail_ch, cleared by reset and start.
REQ-033 RESULT_CHECKER_FAIL_DATA_EN undefined: those ports and their registers do not exist; all other behaviour is identical.

Verification
REQ-034 Bench covers: CHANNELS=4, WIDTH=8, start; 3 cycles ch_valid=4'b1111, mode=0, expected==actual; finish -> pass_cnt=12, fail_cnt=0, done=1, result_ok=1.
REQ-035 Bench covers: ch_valid=4'b0110, mode=4'b0100, ch1 equal, ch2 exp=8'h5A act=8'h5A; finish -> pass_cnt=1, fail_cnt=1, first_fail_ch=2, result_ok=0; with macro, first_fail_expected=first_fail_actual=8'h5A.
REQ-036 Bench covers: failures on ch3 at cycle 2 and ch0 at cycle 4 -> first_fail_ch=3 stays latched; start -> first_fail_valid=0 and counters 0.
REQ-037 Bench covers: CNT_W=4, 5 cycles of 4 passes -> pass_cnt saturates at 15; start and finish together in RUN -> remains RUN, counters cleared.
REQ-038 Bench covers: start then immediate finish with no ch_valid -> result_ok=0; rst_n pulsed low mid-RUN -> all outputs at reset values before the next clk edge.
